// File: rtl/cw305_reg_operand_bank.sv
// Host/core operand register bank with start/busy/done control, cycle counter and sticky error flags.
// Optional REG_WRITE_LOCK_EN: host writes to input operands are dropped while BUSY and set lock_viol.
module cw305_reg_operand_bank #(
  parameter int pADDR_WIDTH    = 21,
  parameter int pBYTECNT_SIZE  = 8,
  parameter int pOPERAND_WIDTH = 256,
  parameter int pWORD_WIDTH    = 32,
  parameter int pNUM_IN        = 3,
  parameter int pNUM_OUT       = 2,
  parameter int pIN_BASE       = 'h10,
  parameter int pOUT_BASE      = 'h20,
  parameter logic [7:0] pIDENTIFY = 8'h2f,
  localparam int NWORDS    = pOPERAND_WIDTH / pWORD_WIDTH,
  localparam int IN_SEL_W  = (pNUM_IN > 1) ? $clog2(pNUM_IN) : 1,
  localparam int OUT_SEL_W = (pNUM_OUT > 1) ? $clog2(pNUM_OUT) : 1,
  localparam int WIDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           read_data,
  input  logic [7:0]                           write_data,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  input  logic                                 exttrigger_in,
  input  logic [IN_SEL_W-1:0]                  in_sel,
  input  logic [WIDX_W-1:0]                    in_addr,
  output logic [pWORD_WIDTH-1:0]               in_word,
  input  logic [OUT_SEL_W-1:0]                 out_sel,
  input  logic [WIDX_W-1:0]                    out_addr,
  input  logic [pWORD_WIDTH-1:0]               out_word,
  input  logic                                 out_wren,
  input  logic                                 I_busy,
  input  logic                                 I_done,
  output logic                                 O_start
);

  // state | meaning
  // IDLE  | no operation requested since reset or last clear
  // BUSY  | core running, cycle counter advancing
  // DONE  | core reported done, result operands valid
  localparam int NBYTES       = pOPERAND_WIDTH / 8;
  localparam int BIDX_W       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int REG_CTRL     = 0;
  localparam int REG_CYCLES   = 1;
  localparam int REG_IDENTIFY = 2;

  typedef logic [NBYTES-1:0][7:0]             op_bytes_t;
  typedef logic [NWORDS-1:0][pWORD_WIDTH-1:0] op_words_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  op_bytes_t         in_op  [pNUM_IN];
  op_words_t         out_op [pNUM_OUT];
  state_t            state_q, state_d;
  logic              start_d, drop_set;
  logic [31:0]       cycles;
  logic [3:0][7:0]   cyc_bytes;
  logic [2:0]        ext_q;
  logic              done_q;
  logic              start_dropped, lock_viol;
  int                addr_i, bc_i;
  logic [BIDX_W-1:0] bidx;
  logic              host_wr, ctrl_wr, go, clr, trig_edge, done_rise, start_req;
  logic              byte_ok, in_wr_en, op_hit;
  logic [7:0]        status, rd_mux;
  op_bytes_t         op_rd;
  op_words_t         in_pick;

  always_comb begin
    addr_i = 32'(reg_address);
    bc_i   = 32'(reg_bytecnt);
  end

  assign bidx      = BIDX_W'(reg_bytecnt);
  assign byte_ok   = bc_i < NBYTES;
  assign host_wr   = reg_write & reg_addrvalid;
  assign ctrl_wr   = host_wr & (addr_i == REG_CTRL);
  assign go        = ctrl_wr & write_data[0];
  assign clr       = ctrl_wr & write_data[1];
  assign trig_edge = ext_q[1] & ~ext_q[2];
  assign done_rise = I_done & ~done_q;
  assign start_req = go | trig_edge;
  assign cyc_bytes = cycles;
  assign status    = {3'b000, lock_viol, start_dropped, I_busy, state_q == DONE, state_q == BUSY};

`ifdef REG_WRITE_LOCK_EN
  logic in_hit;

  always_comb begin
    in_hit = 1'b0;
    for (int i = 0; i < pNUM_IN; i++)
      if (addr_i == pIN_BASE + i) in_hit = 1'b1;
  end

  assign in_wr_en = host_wr & byte_ok & (state_q != BUSY);

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n)                                  lock_viol <= 1'b0;
    else if (host_wr && in_hit && state_q == BUSY) lock_viol <= 1'b1;
    else if (clr)                                  lock_viol <= 1'b0;
  end
`else
  assign in_wr_en  = host_wr & byte_ok;
  assign lock_viol = 1'b0;
`endif

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < pNUM_IN; i++) in_op[i] <= '0;
    end else begin
      for (int i = 0; i < pNUM_IN; i++)
        if (in_wr_en && addr_i == pIN_BASE + i) in_op[i][bidx] <= write_data;
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < pNUM_OUT; j++) out_op[j] <= '0;
    end else begin
      for (int j = 0; j < pNUM_OUT; j++)
        if (out_wren && 32'(out_sel) == j) out_op[j][out_addr] <= out_word;
    end
  end

  // Register reads sample operands before this edge's core write, so the host sees the old word.
  always_comb begin
    rd_mux = 8'h00;
    op_rd  = '0;
    op_hit = 1'b0;
    for (int i = 0; i < pNUM_IN; i++)
      if (addr_i == pIN_BASE + i) begin
        op_hit = 1'b1;
        op_rd  = in_op[i];
      end
    for (int j = 0; j < pNUM_OUT; j++)
      if (addr_i == pOUT_BASE + j) begin
        op_hit = 1'b1;
        op_rd  = out_op[j];
      end
    if (addr_i == REG_CTRL)          rd_mux = status;
    else if (addr_i == REG_CYCLES)   rd_mux = (bc_i < 4) ? cyc_bytes[reg_bytecnt[1:0]] : 8'h00;
    else if (addr_i == REG_IDENTIFY) rd_mux = pIDENTIFY;
    else if (op_hit && byte_ok)      rd_mux = op_rd[bidx];
  end

  always_comb begin
    in_pick = '0;
    for (int i = 0; i < pNUM_IN; i++)
      if (32'(in_sel) == i) in_pick = in_op[i];
  end

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    drop_set = 1'b0;
    case (state_q)
      IDLE: if (start_req) begin
        state_d = BUSY;
        start_d = 1'b1;
      end
      BUSY: begin
        if (done_rise) state_d = DONE;
        drop_set = start_req;
      end
      DONE: if (start_req) begin
        state_d = BUSY;
        start_d = 1'b1;
      end else if (clr) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      O_start       <= 1'b0;
      cycles        <= '0;
      start_dropped <= 1'b0;
      ext_q         <= '0;
      done_q        <= 1'b0;
      read_data     <= 8'h00;
      in_word       <= '0;
    end else begin
      state_q <= state_d;
      O_start <= start_d;
      ext_q   <= {ext_q[1:0], exttrigger_in};
      done_q  <= I_done;
      read_data <= (reg_read && reg_addrvalid) ? rd_mux : 8'h00;
      in_word   <= in_pick[in_addr];
      if (start_d)                                  cycles <= '0;
      else if (state_q == BUSY && cycles != '1)     cycles <= cycles + 32'd1;
      if (drop_set) start_dropped <= 1'b1;
      else if (clr) start_dropped <= 1'b0;
    end
  end

endmodule

// File: doc/cw305_reg_operand_bank.md
Name: cw305_reg_operand_bank

Overview:
Parametrised successor to the fixed k/gx/gy/rx/ry register file used by the point-multiply targets. It provides pNUM_IN host-written input operands and pNUM_OUT core-written result operands, each pOPERAND_WIDTH bits wide. It also contains a start/busy/done status FSM, an operation cycle counter and sticky error flags. It sits between cw305_usb_reg_fe and a crypto core, and runs in a single clock domain (no CDC).

Parameters:
pADDR_WIDTH, 21, total register-bus address width.
pBYTECNT_SIZE, 8, width of reg_bytecnt; reg_address width is pADDR_WIDTH-pBYTECNT_SIZE.
pOPERAND_WIDTH, 256, bits per operand; must be a multiple of pWORD_WIDTH.
pWORD_WIDTH, 32, core-side word width.
pNUM_IN, 3, number of input operands (min 1).
pNUM_OUT, 2, number of result operands (min 1).
pIN_BASE, 'h10, register address of input operand 0; operand i is at pIN_BASE+i.
pOUT_BASE, 'h20, register address of result operand 0; operand j is at pOUT_BASE+j.
pIDENTIFY, 8'h2f, value returned by REG_IDENTIFY.

Ports:
usb_clk  in  1  the only clock
reset_n  in  1  asynchronous, active-low reset
reg_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register address
reg_bytecnt  in  pBYTECNT_SIZE  byte index within the register
read_data  out  8  read byte; valid one cycle after reg_read
write_data  in  8  write byte
reg_read / reg_write / reg_addrvalid  in  1 each  usb_reg_fe strobes
exttrigger_in  in  1  asynchronous external start
in_sel  in  $clog2(pNUM_IN) (min 1)  input operand select
in_addr  in  $clog2(pOPERAND_WIDTH/pWORD_WIDTH) (min 1)  word index
in_word  out  pWORD_WIDTH  registered word of the selected input operand
out_sel  in  $clog2(pNUM_OUT) (min 1)  result operand select
out_addr  in  same as in_addr  word index
out_word  in  pWORD_WIDTH  result word
out_wren  in  1  write out_word into the selected result operand
I_busy  in  1  core busy (status only)
I_done  in  1  core done; level or pulse
O_start  out  1  one-cycle start pulse

Behaviour:
- Reset (reset_n low, asynchronous): all operand bits, read_data, in_word, O_start, cycle counter, flags and sync flops go to 0; FSM goes to IDLE.
- Register map:
  - 0x00 REG_CTRL. Write with write_data[0]=1 requests a start. Write with write_data[1]=1 clears the sticky flags. Read returns {3'b0, lock_viol, start_dropped, I_busy, done, busy}.
  - 0x01 REG_CYCLES: 4-byte cycle counter, bytecnt 0 is the LSB.
  - 0x02 REG_IDENTIFY: returns pIDENTIFY.
  - Operand registers: byte b maps to bits [8b+7:8b].
  - Bytecnt >= pOPERAND_WIDTH/8 reads 0 and ignores writes. Unmapped addresses read 0 and ignore writes.
- Read path: combinational mux, then a register. read_data returns 0 when reg_read or reg_addrvalid is low.
- Host writes to result operands are ignored.
- Core read: in_word <= operand[in_sel][in_addr*pWORD_WIDTH +: pWORD_WIDTH], 1-cycle latency. An out-of-range in_sel returns 0.
- Core write: when out_wren is high, the selected word is written on the same edge. An out-of-range out_sel is ignored.
- Simultaneous core write and host read of the same word: the host sees the old value.
- exttrigger_in passes through a 2-flop synchroniser; a rising edge is detected on the synchronised signal.
- Start request = CTRL go write OR trigger edge. Both in the same cycle count as one start.
- FSM:
  - IDLE --start--> BUSY. O_start=1 for exactly one cycle (registered, asserted in the cycle after the request). Cycle counter cleared to 0.
  - BUSY --rising edge of I_done--> DONE. Rising edge = I_done & ~I_done_q. Done is sticky.
  - DONE --start--> BUSY (same actions as from IDLE).
  - DONE --CTRL clear write--> IDLE.
  - In BUSY, a start is ignored: no O_start, start_dropped is set sticky.
  - I_done outside BUSY is ignored.
- Cycle counter: increments every cycle in BUSY, including the O_start cycle. It saturates at 32'hFFFFFFFF and holds its value in DONE/IDLE.
- Status bits: busy = (state==BUSY); done = (state==DONE).
- Clear write (bit 1) clears start_dropped and lock_viol. It applies in any state; a DONE state also moves to IDLE. If bit0 and bit1 are both set, the clear applies first and then the start.

Optional Feature:
REG_WRITE_LOCK_EN.
- Defined: host writes to input operands while in BUSY are dropped, and lock_viol is set sticky.
- Undefined: such writes take effect immediately, and lock_viol reads 0 permanently.

Test Plan:
1. Reset, then read 0x02 -> 8'h2f; read 0x00 -> 8'h00; read 0x10 bytes 0..31 -> 0.
2. Write 32 bytes 0x00..0x1F to 0x11, then core reads in_sel=1, in_addr=2 -> in_word=32'h0B0A0908 one cycle later; host read back matches; write to bytecnt 40 -> no change.
3. CTRL write 0x01 -> single O_start pulse; I_done pulsed 100 cycles after O_start -> status 0x02, REG_CYCLES=101 (0x65), counter stable afterwards.
4. exttrigger_in rises while BUSY -> no O_start, status 0x09 (start_dropped|busy); CTRL write 0x02 -> start_dropped cleared, still BUSY.
5. Core writes out_sel=0, out_addr=7, out_word=32'hDEADBEEF -> host read 0x20 bytes 28..31 = EF BE AD DE; host write to 0x20 ignored.
6. With REG_WRITE_LOCK_EN: write 0x10 byte 0 in BUSY -> value unchanged, lock_viol=1 (status 0x11). reset_n asserted mid-BUSY -> immediate IDLE, all state and outputs 0.
